// File: rtl/ysyx_22041207_dcache_ctrl.sv
// Request-side controller for the 2-way/4-set D-cache: probes the array, forwards
// misses and write-through stores to memory, and drives cache fill/invalidate.
module ysyx_22041207_dcache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [63:0] c_read_addr,
    input  logic        c_read_hit,
    input  logic [63:0] c_read_data,
    output logic        c_fill_en,
    output logic [63:0] c_fill_addr,
    output logic [63:0] c_fill_data,
    output logic        c_inv_en,
    output logic [63:0] c_inv_addr,
    output logic [63:0] c_inv_data,
    output logic [7:0]  c_inv_mask,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [2:0]  dbg_state_o
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // mem_req fields hold stable while mem_req_valid && !mem_req_ready.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MEM_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;
    logic        miss_q, miss_d;
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        miss_d        = miss_q;
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    rdata_d = 64'd0;
                    miss_d  = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (we_q) begin
                    state_d = S_MEM_REQ;
                end else if (c_read_hit) begin
                    rdata_d     = c_read_data;
                    perf_hits_d = perf_hits_q + 32'd1;
                    state_d     = S_RESP;
                end else begin
                    miss_d        = 1'b1;
                    perf_misses_d = perf_misses_q + 32'd1;
                    state_d       = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    if (!we_q) rdata_d = mem_resp_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            addr_q        <= 64'd0;
            wdata_q       <= 64'd0;
            wmask_q       <= 8'd0;
            rdata_q       <= 64'd0;
            miss_q        <= 1'b0;
            perf_hits_q   <= 32'd0;
            perf_misses_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            rdata_q       <= rdata_d;
            miss_q        <= miss_d;
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    // Every output is decoded from registered state so idle cycles present zeros.
    always_comb begin
        req_ready     = (state_q == S_IDLE) && !rst;
        resp_valid    = 1'b0;
        resp_rdata    = 64'd0;
        c_read_addr   = 64'd0;
        c_fill_en     = 1'b0;
        c_fill_addr   = 64'd0;
        c_fill_data   = 64'd0;
        c_inv_en      = 1'b0;
        c_inv_addr    = 64'd0;
        c_inv_data    = 64'd0;
        c_inv_mask    = 8'd0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = 64'd0;
        mem_req_wdata = 64'd0;
        mem_req_wmask = 8'd0;
        case (state_q)
            S_LOOKUP: begin
                c_read_addr = addr_q;
                if (we_q) begin
                    c_inv_en   = 1'b1;
                    c_inv_addr = addr_q;
                    c_inv_data = wdata_q;
                    c_inv_mask = wmask_q;
                end
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = we_q;
                mem_req_addr  = {addr_q[63:3], 3'b000};
                mem_req_wdata = wdata_q;
                mem_req_wmask = we_q ? wmask_q : 8'd0;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = we_q ? 64'd0 : rdata_q;
                if (miss_q) begin
                    c_fill_en   = 1'b1;
                    c_fill_addr = {addr_q[63:3], 3'b000};
                    c_fill_data = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22041207_dcache_ctrl.sv
// Directed bench for the D-cache request controller; each task checks one scenario
// cycle by cycle, sampling on the falling edge.
module tb_ysyx_22041207_dcache_ctrl;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [63:0] c_read_addr;
  logic        c_read_hit;
  logic [63:0] c_read_data;
  logic        c_fill_en;
  logic [63:0] c_fill_addr;
  logic [63:0] c_fill_data;
  logic        c_inv_en;
  logic [63:0] c_inv_addr;
  logic [63:0] c_inv_data;
  logic [7:0]  c_inv_mask;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
  logic [2:0]  dbg_state;

  int n_cmp;
  int n_bad;

  ysyx_22041207_dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .c_read_addr(c_read_addr), .c_read_hit(c_read_hit), .c_read_data(c_read_data),
    .c_fill_en(c_fill_en), .c_fill_addr(c_fill_addr), .c_fill_data(c_fill_data),
    .c_inv_en(c_inv_en), .c_inv_addr(c_inv_addr), .c_inv_data(c_inv_data),
    .c_inv_mask(c_inv_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .perf_hits(perf_hits), .perf_misses(perf_misses),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    c_read_hit = 1'b0; c_read_data = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) step();
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %0b want 0", req_ready); end
    rst = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
    n_cmp++; if ({resp_valid, mem_req_valid, c_fill_en, c_inv_en} !== 4'b0000) begin n_bad++; $display("FAIL reset_valids: got %b want 0000", {resp_valid, mem_req_valid, c_fill_en, c_inv_en}); end
    n_cmp++; if ({resp_rdata, c_read_addr, mem_req_addr, c_fill_addr} !== 256'd0) begin n_bad++; $display("FAIL reset_data: got nonzero address/data outputs"); end
    n_cmp++; if ({perf_hits, perf_misses} !== 64'd0) begin n_bad++; $display("FAIL reset_counters: got %h/%h want 0/0", perf_hits, perf_misses); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_load_miss();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0010; req_wdata = '0; req_wmask = '0;
    c_read_hit = 1'b0; c_read_data = '0; mem_req_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL miss_ready: got %0b want 1", req_ready); end
    step(); req_valid = 1'b0;  // T+1
    n_cmp++; if (c_read_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL miss_probe_addr: got %h want 80000010", c_read_addr); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL miss_early_mem: got %0b want 0", mem_req_valid); end
    step();                    // T+2
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL miss_mem_valid: got %0b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL miss_mem_addr: got %h want 80000010", mem_req_addr); end
    n_cmp++; if ({mem_req_we, mem_req_wmask} !== 9'd0) begin n_bad++; $display("FAIL miss_mem_we_mask: got %b want 0", {mem_req_we, mem_req_wmask}); end
    n_cmp++; if (c_read_addr !== 64'd0) begin n_bad++; $display("FAIL miss_probe_idle: got %h want 0", c_read_addr); end
    n_cmp++; if (perf_misses !== 32'd1) begin n_bad++; $display("FAIL miss_count: got %0d want 1", perf_misses); end
    step();                    // T+3
    n_cmp++; if ({mem_req_valid, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL miss_wait: got %b want 00", {mem_req_valid, resp_valid}); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_0123_4567;
    step();                    // T+4
    mem_resp_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL miss_resp_valid: got %0b want 1", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL miss_resp_data: got %h want deadbeef01234567", resp_rdata); end
    n_cmp++; if (c_fill_en !== 1'b1) begin n_bad++; $display("FAIL miss_fill_en: got %0b want 1", c_fill_en); end
    n_cmp++; if (c_fill_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL miss_fill_addr: got %h want 80000010", c_fill_addr); end
    n_cmp++; if (c_fill_data !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL miss_fill_data: got %h want deadbeef01234567", c_fill_data); end
    n_cmp++; if (perf_hits !== 32'd0) begin n_bad++; $display("FAIL miss_hits: got %0d want 0", perf_hits); end
    step();                    // T+5
    n_cmp++; if ({resp_valid, c_fill_en, req_ready} !== 3'b001) begin n_bad++; $display("FAIL miss_done: got %b want 001", {resp_valid, c_fill_en, req_ready}); end
  endtask

  task automatic test_load_hit();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0010;
    c_read_hit = 1'b1; c_read_data = 64'hDEAD_BEEF_0123_4567; mem_req_ready = 1'b1;
    step(); req_valid = 1'b0;  // T+1
    n_cmp++; if ({mem_req_valid, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL hit_t1: got %b want 00", {mem_req_valid, resp_valid}); end
    step();                    // T+2
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL hit_resp_valid: got %0b want 1", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL hit_resp_data: got %h want deadbeef01234567", resp_rdata); end
    n_cmp++; if ({mem_req_valid, c_fill_en} !== 2'b00) begin n_bad++; $display("FAIL hit_no_mem_fill: got %b want 00", {mem_req_valid, c_fill_en}); end
    n_cmp++; if ({perf_hits, perf_misses} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL hit_counts: got %0d/%0d want 1/1", perf_hits, perf_misses); end
    step();
    c_read_hit = 1'b0;
  endtask

  task automatic test_store();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h8000_0013;
    req_wdata = 64'h0000_0000_AB00_0000; req_wmask = 8'h08; mem_req_ready = 1'b1;
    step(); req_valid = 1'b0;  // T+1
    n_cmp++; if (c_inv_en !== 1'b1) begin n_bad++; $display("FAIL st_inv_en: got %0b want 1", c_inv_en); end
    n_cmp++; if (c_inv_addr !== 64'h8000_0013) begin n_bad++; $display("FAIL st_inv_addr: got %h want 80000013", c_inv_addr); end
    n_cmp++; if (c_inv_data !== 64'h0000_0000_AB00_0000) begin n_bad++; $display("FAIL st_inv_data: got %h want ab000000", c_inv_data); end
    n_cmp++; if (c_inv_mask !== 8'h08) begin n_bad++; $display("FAIL st_inv_mask: got %h want 08", c_inv_mask); end
    step();                    // T+2
    n_cmp++; if (c_inv_en !== 1'b0) begin n_bad++; $display("FAIL st_inv_pulse: got %0b want 0", c_inv_en); end
    n_cmp++; if ({mem_req_valid, mem_req_we} !== 2'b11) begin n_bad++; $display("FAIL st_mem_valid_we: got %b want 11", {mem_req_valid, mem_req_we}); end
    n_cmp++; if (mem_req_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL st_mem_addr: got %h want 80000010", mem_req_addr); end
    n_cmp++; if (mem_req_wdata !== 64'h0000_0000_AB00_0000) begin n_bad++; $display("FAIL st_mem_wdata: got %h want ab000000", mem_req_wdata); end
    n_cmp++; if (mem_req_wmask !== 8'h08) begin n_bad++; $display("FAIL st_mem_wmask: got %h want 08", mem_req_wmask); end
    step();                    // T+3
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678;
    step();                    // T+4
    mem_resp_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL st_resp_valid: got %0b want 1", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'd0) begin n_bad++; $display("FAIL st_resp_data: got %h want 0", resp_rdata); end
    n_cmp++; if (c_fill_en !== 1'b0) begin n_bad++; $display("FAIL st_no_fill: got %0b want 0", c_fill_en); end
    n_cmp++; if ({perf_hits, perf_misses} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL st_counts: got %0d/%0d want 1/1", perf_hits, perf_misses); end
    step();
    req_we = 1'b0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0100;
    c_read_hit = 1'b1; c_read_data = 64'h1111;
    step(); req_addr = 64'h8000_0108;  // T+1, request stays valid
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %0b want 0", req_ready); end
    step();                            // T+2
    n_cmp++; if ({resp_valid, req_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b_resp1: got %b want 10", {resp_valid, req_ready}); end
    n_cmp++; if (resp_rdata !== 64'h1111) begin n_bad++; $display("FAIL b2b_data1: got %h want 1111", resp_rdata); end
    c_read_data = 64'h2222;
    step();                            // T+3: accepted here
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL b2b_idle: got %b want 01", {resp_valid, req_ready}); end
    step(); req_valid = 1'b0;          // T+4
    n_cmp++; if (c_read_addr !== 64'h8000_0108) begin n_bad++; $display("FAIL b2b_probe2: got %h want 80000108", c_read_addr); end
    step();                            // T+5
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 64'h2222}) begin n_bad++; $display("FAIL b2b_resp2: got %0b/%h want 1/2222", resp_valid, resp_rdata); end
    n_cmp++; if (perf_hits !== 32'd3) begin n_bad++; $display("FAIL b2b_hits: got %0d want 3", perf_hits); end
    step();
    c_read_hit = 1'b0;
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_002C; mem_req_ready = 1'b0;
    step(); req_valid = 1'b0;  // T+1
    for (int k = 0; k < 5; k++) begin
      step();                  // T+2 .. T+6
      n_cmp++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wmask, resp_valid} !== {1'b1, 1'b0, 64'h8000_0028, 8'h00, 1'b0})
        begin n_bad++; $display("FAIL stall_hold%0d: got v=%0b a=%h want v=1 a=80000028", k, mem_req_valid, mem_req_addr); end
    end
    step();                    // T+7
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stall_last: got %0b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    step();                    // T+8
    n_cmp++; if ({mem_req_valid, dbg_state} !== {1'b0, 3'd3}) begin n_bad++; $display("FAIL stall_wait: got %0b/%0d want 0/3", mem_req_valid, dbg_state); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_AAAA_0F0F_F0F0;
    step();                    // T+9
    mem_resp_valid = 1'b0;
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 64'h5555_AAAA_0F0F_F0F0}) begin n_bad++; $display("FAIL stall_resp: got %0b/%h want 1/5555aaaa0f0ff0f0", resp_valid, resp_rdata); end
    n_cmp++; if (c_fill_addr !== 64'h8000_0028) begin n_bad++; $display("FAIL stall_fill_addr: got %h want 80000028", c_fill_addr); end
    n_cmp++; if (perf_misses !== 32'd2) begin n_bad++; $display("FAIL stall_misses: got %0d want 2", perf_misses); end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0040; mem_req_ready = 1'b1;
    step(); req_valid = 1'b0;  // T+1
    step();                    // T+2
    step();                    // T+3
    n_cmp++; if (dbg_state !== 3'd3) begin n_bad++; $display("FAIL rmid_in_wait: got %0d want 3", dbg_state); end
    rst = 1'b1;
    step();                    // T+4
    n_cmp++; if ({req_ready, resp_valid, mem_req_valid, c_fill_en} !== 4'b0000) begin n_bad++; $display("FAIL rmid_in_rst: got %b want 0000", {req_ready, resp_valid, mem_req_valid, c_fill_en}); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0_BAD0;
    step();                    // T+5
    mem_resp_valid = 1'b0;
    n_cmp++; if ({resp_valid, c_fill_en, req_ready} !== 3'b001) begin n_bad++; $display("FAIL rmid_after: got %b want 001", {resp_valid, c_fill_en, req_ready}); end
    n_cmp++; if (perf_misses !== 32'd0) begin n_bad++; $display("FAIL rmid_counter_clr: got %0d want 0", perf_misses); end
    step();
    n_cmp++; if ({resp_valid, dbg_state} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL rmid_spurious: got %0b/%0d want 0/0", resp_valid, dbg_state); end
  endtask

  task automatic test_counter_wrap();
    force dut.perf_misses_d = 32'hFFFF_FFFF;
    step();
    release dut.perf_misses_d;
    n_cmp++; if (perf_misses !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", perf_misses); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0080; c_read_hit = 1'b0; mem_req_ready = 1'b1;
    step(); req_valid = 1'b0;  // T+1
    step();                    // T+2
    n_cmp++; if (perf_misses !== 32'd0) begin n_bad++; $display("FAIL wrap_misses: got %h want 0", perf_misses); end
    n_cmp++; if (perf_hits !== 32'd0) begin n_bad++; $display("FAIL wrap_hits: got %0d want 0", perf_hits); end
    step();                    // T+3
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h77;
    step();                    // T+4
    mem_resp_valid = 1'b0;
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 64'h77}) begin n_bad++; $display("FAIL wrap_resp: got %0b/%h want 1/77", resp_valid, resp_rdata); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_dcache_ctrl.md
# ysyx_22041207_dcache_ctrl

Request-side controller for the 2-way, 4-set, 64-bit-line data cache: it accepts CPU load/store requests, probes the cache, services misses and stores from memory, and drives the cache's fill (read-update) and invalidate (write-update) ports. It sits between the LSU and the memory bus, with the cache array as a side unit it controls.

## Interface
- No parameters; data width 64, address width 64, line = one 8-byte word.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept; high only in IDLE and not in rst
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data (lane-aligned)
- req_wmask  in  8  store byte mask
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  aligned load word; 0 for stores
- c_read_addr  out  64  cache probe address
- c_read_hit  in  1  cache hit (combinational from c_read_addr)
- c_read_data  in  64  cache hit data
- c_fill_en / c_fill_addr / c_fill_data  out  1/64/64  cache fill on load miss
- c_inv_en / c_inv_addr / c_inv_data / c_inv_mask  out  1/64/64/8  cache store-invalidate
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we / mem_req_addr / mem_req_wdata / mem_req_wmask  out  1/64/64/8
- mem_resp_valid  in  1  memory response (one per request)
- mem_resp_rdata  in  64  load data
- perf_hits / perf_misses  out  32  load hit/miss counters, wrap at 2^32

## Operation
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- IDLE: req_ready=1; on req_valid latch we/addr/wdata/wmask -> LOOKUP.
- LOOKUP: c_read_addr = latched addr (c_read_addr is 0 in every other state). Load hit: capture c_read_data, perf_hits+1 -> RESP. Load miss: perf_misses+1 -> MEM_REQ. Store: pulse c_inv_en with addr/wdata/wmask -> MEM_REQ (write-through, no-allocate).
- MEM_REQ: mem_req_valid=1 with address {addr[63:3],3'b0}, we, wdata, wmask (wmask 0 for loads); held stable until mem_req_ready sampled high -> MEM_WAIT.
- MEM_WAIT: on mem_resp_valid capture mem_resp_rdata (loads) -> RESP. mem_resp_valid in any other state is ignored.
- RESP: resp_valid=1, resp_rdata = captured word (0 for stores); if it was a load miss, c_fill_en=1 with c_fill_addr={addr[63:3],3'b0}, c_fill_data=captured word -> IDLE.
- Only one outstanding transaction; no store buffering.
- Counters count loads only; wrap from 0xFFFF_FFFF to 0.

## Timing
- Reset: state IDLE; req_ready, resp_valid, mem_req_valid, c_fill_en, c_inv_en = 0; resp_rdata, counters, all address/data outputs = 0. req_ready stays 0 in any cycle rst is high.
- Load hit: accepted at cycle T, resp_valid at T+2.
- Miss/store: mem_req_valid first at T+2; if mem_req_ready at T+2 and mem_resp_valid at T+3, resp_valid at T+4. Each memory stall cycle adds one.
- c_inv_en is a single-cycle pulse at T+1; c_fill_en coincides with resp_valid.
- Back-to-back: next request can be accepted the cycle after RESP (min 3 cycles per request).
- rst mid-transaction: next cycle IDLE, no resp_valid, no fill, mem_req_valid dropped; memory side is reset by the same rst.
- All outputs are functions of registered state and latched fields only, except c_read_hit/c_read_data consumption inside LOOKUP.

## Test plan
- Reset then load 0x8000_0010, cache miss, mem_req_ready=1 at once, mem_resp 1 cycle later with 0xDEAD_BEEF_0123_4567 -> mem_req_addr 0x8000_0010, resp at T+4 with that data, c_fill_en same cycle, perf_misses=1.
- Repeat same load with cache hit returning 0xDEAD_BEEF_0123_4567 -> resp_valid at T+2, no mem_req_valid, perf_hits=1.
- Store 0x8000_0013 wdata 0xAB<<24 mask 0x08 -> c_inv_en pulse at T+1, mem_req we=1 addr 0x8000_0010 mask 0x08, resp_rdata 0, no fill.
- mem_req_ready held low 5 cycles -> mem_req_valid and all mem_req fields stable throughout; resp 5 cycles later than baseline.
- rst asserted during MEM_WAIT, then spurious mem_resp_valid -> no resp_valid, no c_fill_en, req_ready=1 after rst drops.
- Preload perf_misses to 0xFFFF_FFFF via 2^32-1 misses (or forced) then one miss -> perf_misses=0.
